// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port refill arbiter (mem_arbiter).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

  localparam int BURST_LEN_DEF = 4;

  // One extra bit so the counter can represent BURST_LEN itself.
  function automatic int cnt_width(input int len);
    return $clog2(len) + 1;
  endfunction

endpackage

// File: rtl/mem_arb_beat_cnt.sv
// Beat counter for one refill burst; done flags the beat that brings the count to BURST_LEN.
module mem_arb_beat_cnt
  import mem_arb_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam int CW = cnt_width(BURST_LEN);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear)
      count_next = '0;
    else if (inc)
      count_next = count_reg + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  // Look at the post-increment value so the FSM can leave BURST on the final beat itself.
  assign done = (count_next == CW'(BURST_LEN));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache refill bursts onto one memory port.
// Optional round-robin on simultaneous requests: define MEM_ARB_RR_EN (default: IC priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_ic2arb,
  input  logic [ADR_WIDTH-1:0]  adr_ic2arb,
  output logic                  ack_arb2ic,
  output logic [DATA_WIDTH-1:0] dat_arb2ic,
  input  logic                  req_dc2arb,
  input  logic [ADR_WIDTH-1:0]  adr_dc2arb,
  output logic                  ack_arb2dc,
  output logic [DATA_WIDTH-1:0] dat_arb2dc,
  output logic                  req_arb2mem,
  output logic [ADR_WIDTH-1:0]  adr_arb2mem,
  input  logic                  ack_mem2arb,
  input  logic [DATA_WIDTH-1:0] dat_mem2arb,
  output logic                  busy
);

  state_t               state_reg, state_next;
  owner_t               owner_reg, owner_next;
  owner_t               winner;
  logic [ADR_WIDTH-1:0] adr_reg, adr_next;
  logic                 grant, beat, done;

`ifdef MEM_ARB_RR_EN
  owner_t last_reg;

  always_comb begin
    if (req_ic2arb && req_dc2arb)
      winner = (last_reg == OWN_IC) ? OWN_DC : OWN_IC;
    else
      winner = req_ic2arb ? OWN_IC : OWN_DC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_reg <= OWN_DC;
    else if (grant)
      last_reg <= winner;
  end
`else
  always_comb begin
    winner = req_ic2arb ? OWN_IC : OWN_DC;
  end
`endif

  // Requests are only looked at in IDLE, so RELEASE blocks a stale regrant.
  assign grant = (state_reg == IDLE) && (req_ic2arb || req_dc2arb);
  assign beat  = (state_reg == BURST) && ack_mem2arb;

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    adr_next   = adr_reg;
    case (state_reg)
      IDLE: begin
        if (grant) begin
          state_next = BURST;
          owner_next = winner;
          adr_next   = (winner == OWN_IC) ? adr_ic2arb : adr_dc2arb;
        end
      end
      BURST:   if (done) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= OWN_IC;
      adr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      adr_reg   <= adr_next;
    end
  end

  mem_arb_beat_cnt #(
    .BURST_LEN (BURST_LEN)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (grant),
    .inc   (beat),
    .done  (done)
  );

  assign busy        = (state_reg == BURST);
  assign req_arb2mem = busy;
  assign adr_arb2mem = adr_reg;
  assign ack_arb2ic  = beat && (owner_reg == OWN_IC);
  assign ack_arb2dc  = beat && (owner_reg == OWN_DC);
  assign dat_arb2ic  = dat_mem2arb;
  assign dat_arb2dc  = dat_mem2arb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter plus hand sequences for grant order and reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_ic, req_dc, ack_mem;
  logic [31:0] adr_ic, adr_dc, dat_mem;
  logic        ack_ic, ack_dc, req_mem, busy;
  logic [31:0] dat_ic, dat_dc, adr_mem;

  mem_arbiter #(
    .ADR_WIDTH  (32),
    .DATA_WIDTH (32),
    .BURST_LEN  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_ic2arb  (req_ic),
    .adr_ic2arb  (adr_ic),
    .ack_arb2ic  (ack_ic),
    .dat_arb2ic  (dat_ic),
    .req_dc2arb  (req_dc),
    .adr_dc2arb  (adr_dc),
    .ack_arb2dc  (ack_dc),
    .dat_arb2dc  (dat_dc),
    .req_arb2mem (req_mem),
    .adr_arb2mem (adr_mem),
    .ack_mem2arb (ack_mem),
    .dat_mem2arb (dat_mem),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [31:0] A_IC1 = 32'hFF07BD08;
  localparam logic [31:0] A_IC2 = 32'hA5552D0C;
  localparam logic [31:0] A_DC  = 32'hD500AD00;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    bit          ric, rdc;
    logic [31:0] aic, adc;
    bit          ack;
    logic [31:0] dat;
    bit          eic, edc, ebusy, cadr;
    logic [31:0] eadr;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic add(input bit ric, input bit rdc, input logic [31:0] aic, input logic [31:0] adc,
                     input bit ack, input logic [31:0] dat, input bit eic, input bit edc,
                     input bit eb, input bit ca, input logic [31:0] ea);
    vec_t v;
    v.ric = ric; v.rdc = rdc; v.aic = aic; v.adc = adc; v.ack = ack; v.dat = dat;
    v.eic = eic; v.edc = edc; v.ebusy = eb; v.cadr = ca; v.eadr = ea;
    vecs.push_back(v);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle's inputs just after the falling edge; outputs are checked 1 ns later.
  task automatic cyc(input bit ric, input bit rdc, input bit ak, input logic [31:0] d);
    @(negedge clk);
    req_ic = ric; req_dc = rdc; ack_mem = ak; dat_mem = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_ic = 1'b0; req_dc = 1'b0; ack_mem = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_ic = 1'b0; req_dc = 1'b0; adr_ic = '0; adr_dc = '0;
    ack_mem = 1'b1; dat_mem = 32'h5A5A5A5A;
    #3;
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_req_mem", req_mem, 1'b0);
    chk1("reset_ack_ic", ack_ic, 1'b0);
    chk1("reset_ack_dc", ack_dc, 1'b0);
    chk32("reset_adr_mem", adr_mem, 32'h0);
    @(negedge clk);
    ack_mem = 1'b0;
    rst = 1'b0;

    // IC burst: 5 wait cycles, 4 back-to-back beats, address changes mid-burst ignored.
    add(H, L, A_IC1, 0, L, 0, L, L, L, L, 0);
    add(L, L, A_IC1, 0, L, 0, L, L, H, H, A_IC1);
    add(L, L, A_IC1, 0, L, 0, L, L, H, H, A_IC1);
    add(L, L, 32'h12345678, 0, L, 0, L, L, H, H, A_IC1);
    add(L, L, 32'h12345678, 0, L, 0, L, L, H, H, A_IC1);
    add(L, L, A_IC1, 0, L, 0, L, L, H, H, A_IC1);
    for (int i = 0; i < 4; i++)
      add(L, L, 32'h0BADF00D, 0, H, 32'hFFFFFFFF, H, L, H, H, A_IC1);
    add(L, L, 0, 0, L, 0, L, L, L, L, 0);                // RELEASE
    add(L, L, 0, 0, H, 32'hCAFE0001, L, L, L, L, 0);     // stray ack in IDLE
    add(L, L, 0, 0, L, 0, L, L, L, L, 0);
    // DC burst with gapped acks 1,0,1,1,0,1.
    add(L, H, 0, A_DC, L, 0, L, L, L, L, 0);
    add(L, L, 0, A_DC, H, 32'h11, L, H, H, H, A_DC);
    add(L, L, 0, A_DC, L, 32'h0, L, L, H, H, A_DC);
    add(L, L, 0, A_DC, H, 32'h22, L, H, H, H, A_DC);
    add(L, L, 0, A_DC, H, 32'h33, L, H, H, H, A_DC);
    add(L, L, 0, A_DC, L, 32'h0, L, L, H, H, A_DC);
    add(L, L, 0, A_DC, H, 32'h44, L, H, H, H, A_DC);
    add(L, L, 0, 0, H, 32'h55, L, L, L, L, 0);           // RELEASE ignores ack
    add(L, L, 0, 0, L, 0, L, L, L, L, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      req_ic = vecs[i].ric; req_dc = vecs[i].rdc; adr_ic = vecs[i].aic; adr_dc = vecs[i].adc;
      ack_mem = vecs[i].ack; dat_mem = vecs[i].dat;
      #1;
      $display("vec %0d: req_ic=%b req_dc=%b ack=%b -> ack_ic=%b ack_dc=%b busy=%b adr=%h",
               i, req_ic, req_dc, ack_mem, ack_ic, ack_dc, busy, adr_mem);
      chk1($sformatf("vec%0d_ack_ic", i), ack_ic, vecs[i].eic);
      chk1($sformatf("vec%0d_ack_dc", i), ack_dc, vecs[i].edc);
      chk1($sformatf("vec%0d_busy", i), busy, vecs[i].ebusy);
      chk1($sformatf("vec%0d_req_mem", i), req_mem, vecs[i].ebusy);
      chk32($sformatf("vec%0d_dat_ic", i), dat_ic, vecs[i].dat);
      chk32($sformatf("vec%0d_dat_dc", i), dat_dc, vecs[i].dat);
      if (vecs[i].cadr) chk32($sformatf("vec%0d_adr", i), adr_mem, vecs[i].eadr);
    end

    // Simultaneous requests held through the first burst.
    do_reset();
    adr_ic = A_IC2; adr_dc = A_DC;
    cyc(H, H, L, 0);
    chk1("sim_idle_busy", busy, 1'b0);
    cyc(H, H, L, 0);
    chk1("sim_first_busy", busy, 1'b1);
    chk32("sim_first_adr", adr_mem, A_IC2);
    for (int i = 0; i < 4; i++) begin
      cyc(H, H, H, 32'h100 + 32'(i));
      $display("sim beat %0d: ack_ic=%b ack_dc=%b", i, ack_ic, ack_dc);
      chk1($sformatf("sim_beat%0d_ack_ic", i), ack_ic, 1'b1);
      chk1($sformatf("sim_beat%0d_ack_dc", i), ack_dc, 1'b0);
    end
    cyc(H, H, L, 0);
    chk1("sim_release_busy", busy, 1'b0);
    cyc(H, H, L, 0);
    chk1("sim_reidle_busy", busy, 1'b0);
    cyc(H, H, H, 32'h200);
    $display("sim second grant: adr=%h ack_ic=%b ack_dc=%b", adr_mem, ack_ic, ack_dc);
    chk1("sim_second_busy", busy, 1'b1);
    chk32("sim_second_adr", adr_mem, RR ? A_DC : A_IC2);
    chk1("sim_second_ack_ic", ack_ic, !RR);
    chk1("sim_second_ack_dc", ack_dc, RR);

    // Reset after beat 2 of a DC burst, then a fresh IC grant.
    do_reset();
    adr_dc = A_DC; adr_ic = A_IC1;
    cyc(L, H, L, 0);
    cyc(L, L, H, 32'h1);
    chk1("rst_beat1_ack_dc", ack_dc, 1'b1);
    cyc(L, L, H, 32'h2);
    chk1("rst_beat2_ack_dc", ack_dc, 1'b1);
    @(negedge clk);
    ack_mem = 1'b1;
    #2 rst = 1'b1;
    #1;
    $display("rst mid-burst: busy=%b req_mem=%b ack_ic=%b ack_dc=%b adr=%h",
             busy, req_mem, ack_ic, ack_dc, adr_mem);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_req_mem", req_mem, 1'b0);
    chk1("rst_ack_ic", ack_ic, 1'b0);
    chk1("rst_ack_dc", ack_dc, 1'b0);
    chk32("rst_adr", adr_mem, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    cyc(L, L, H, 32'h3);
    chk1("post_rst_ack_dc", ack_dc, 1'b0);
    chk1("post_rst_busy", busy, 1'b0);
    cyc(H, L, L, 0);
    chk1("post_rst_idle", busy, 1'b0);
    cyc(L, L, H, 32'h4);
    chk1("post_rst_ic_busy", busy, 1'b1);
    chk32("post_rst_ic_adr", adr_mem, A_IC1);
    chk1("post_rst_ack_ic", ack_ic, 1'b1);

    // DC holds its request: RELEASE blocks regrant, then a full fresh burst follows.
    do_reset();
    adr_dc = A_DC;
    cyc(L, H, L, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(L, H, H, 32'h300 + 32'(i));
      chk1($sformatf("hold_beat%0d_ack_dc", i), ack_dc, 1'b1);
    end
    cyc(L, H, L, 0);
    chk1("hold_release_busy", busy, 1'b0);
    cyc(L, H, L, 0);
    chk1("hold_idle_busy", busy, 1'b0);
    cyc(L, H, L, 0);
    $display("hold regrant: busy=%b adr=%h", busy, adr_mem);
    chk1("hold_regrant_busy", busy, 1'b1);
    chk32("hold_regrant_adr", adr_mem, A_DC);
    for (int i = 0; i < 3; i++) begin
      cyc(L, H, H, 32'h400 + 32'(i));
      chk1($sformatf("hold2_beat%0d_ack_dc", i), ack_dc, 1'b1);
    end
    cyc(L, H, L, 0);
    chk1("hold2_still_busy", busy, 1'b1);
    cyc(L, L, H, 32'h403);
    chk1("hold2_beat3_ack_dc", ack_dc, 1'b1);
    cyc(L, L, L, 0);
    chk1("hold2_done_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADR_WIDTH, 32, address width; DATA_WIDTH, 32, beat width; BURST_LEN, 4, beats per refill.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_ic2arb  in  1  instruction-cache refill request (level).
- adr_ic2arb  in  ADR_WIDTH  instruction-cache refill address.
- ack_arb2ic  out  1  beat valid to instruction cache.
- dat_arb2ic  out  DATA_WIDTH  beat data to instruction cache.
- req_dc2arb  in  1  data-cache refill request (level).
- adr_dc2arb  in  ADR_WIDTH  data-cache refill address.
- ack_arb2dc  out  1  beat valid to data cache.
- dat_arb2dc  out  DATA_WIDTH  beat data to data cache.
- req_arb2mem  out  1  request to memory.
- adr_arb2mem  out  ADR_WIDTH  address to memory.
- ack_mem2arb  in  1  memory beat valid.
- dat_mem2arb  in  DATA_WIDTH  memory beat data.
- busy  out  1  burst in progress.

Function
REQ-003 The FSM SHALL have states IDLE, BURST and RELEASE.
REQ-004 In IDLE, if any request is high at a rising edge, the block SHALL register the winner (owner) and its address and enter BURST.
REQ-005 req_arb2mem, busy and adr_arb2mem SHALL be valid from the first cycle of BURST, one cycle after the winning request is sampled.
REQ-006 adr_arb2mem SHALL hold the registered address, stable for the whole burst and unaffected by requester address changes.
REQ-007 In BURST, each cycle with ack_mem2arb high SHALL count one beat. Gaps between beats SHALL be allowed. Wait time before the first beat SHALL be unbounded.
REQ-008 ack_arb2ic SHALL equal ack_mem2arb AND (state is BURST) AND (owner is IC); ack_arb2dc SHALL be defined the same way with owner DC. Both are combinational with zero latency.
REQ-009 dat_arb2ic and dat_arb2dc SHALL both pass dat_mem2arb combinationally; only the owner's ack qualifies it.
REQ-010 On the cycle of beat BURST_LEN, the FSM SHALL go to RELEASE. req_arb2mem and busy SHALL deassert in that next cycle.
REQ-011 RELEASE SHALL last exactly one cycle, ignore all requests, and then return to IDLE. This keeps a requester's stale request from being re-granted.
REQ-012 ack_mem2arb in IDLE or RELEASE SHALL be ignored and SHALL NOT be forwarded.
REQ-013 If the owner drops its request mid-burst, the burst SHALL still complete BURST_LEN beats and acks SHALL still be forwarded.
REQ-014 A request from the non-owner during BURST SHALL be held pending, with no effect, until IDLE.
REQ-015 The beat counter SHALL be ceil(log2(BURST_LEN))+1 bits wide and SHALL clear on entry to BURST.

Reset
REQ-016 rst high SHALL force IDLE asynchronously and clear the beat counter and owner. All of these outputs SHALL be 0: req_arb2mem, busy, ack_arb2ic, ack_arb2dc, adr_arb2mem. The round-robin pointer SHALL be set to "last grant = DC".
REQ-017 A reset during BURST SHALL abandon the burst; beats arriving after reset release SHALL be ignored per REQ-012.

Configuration
REQ-018 With MEM_ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted to the requester not granted last, and the pointer SHALL update on every grant.
REQ-019 Without MEM_ARB_RR_EN, IC SHALL always win simultaneous requests and no pointer register SHALL exist.

Structure
REQ-020 Package mem_arb_pkg SHALL hold the state enum, the owner encoding (OWN_IC=0, OWN_DC=1) and the default BURST_LEN.
REQ-021 One sub-module, mem_arb_beat_cnt, SHALL be used. Its inputs are clear and inc; its output is done when count==BURST_LEN.

Verification
REQ-022 IC alone, adr 0xFF07BD08; memory waits 5 cycles then gives 4 consecutive acks of 0xFFFFFFFF. Required: adr_arb2mem=0xFF07BD08, 4 ack_arb2ic pulses, 0 ack_arb2dc, busy low 1 cycle after beat 4.
REQ-023 IC and DC both request in the same cycle (IC 0xA5552D0C, DC 0xD500AD00). With RR: IC served first, then DC after RELEASE. Without RR: same first grant, and a repeated IC request beats DC again.
REQ-024 Acks with gaps (pattern 1,0,1,1,0,1) -> exactly 4 beats counted, burst ends on the 4th ack.
REQ-025 ack_mem2arb pulsed in IDLE -> no ack to either cache and no state change.
REQ-026 rst asserted after beat 2 of a DC burst -> all outputs 0 immediately, and a new IC request afterwards is granted normally.
REQ-027 DC holds its request through the end of its burst -> RELEASE blocks a regrant; with no IC request, DC is regranted in the cycle after IDLE is re-entered.
